mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between two requesters.
  - m0: CPU core port, carrying both fetch and data accesses.
  - m1: auxiliary loader/debug port.
- Sits between the requesters and MEM. Drives the memory address, data, write-enable and byte-select lines.
- Default policy is fixed priority for m0, with a starvation guard for m1. Supports locked back-to-back sequences for read-modify-write.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory side.
- MAX_WAIT, 8, number of consecutive stalled cycles after which m1 must win arbitration (range 1..255).
- LOCK_MAX, 16, maximum cycles a lock may be held before it is force-released (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- m0_req  in  1  m0 access request.
- m0_we  in  1  m0 write (1) / read (0).
- m0_lock  in  1  keep ownership after this transfer.
- m0_addr  in  ADDR_W  m0 address.
- m0_wdata  in  32  m0 write data.
- m0_size  in  2  0=word, 1=half, 2=byte; 3 is illegal and treated as word.
- m0_gnt  out  1  transfer accepted this cycle.
- m0_rvalid  out  1  read data valid (one cycle after the read grant).
- m0_rdata  out  32  registered read data.
- m1_*  same set as m0_*, for requester m1.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_wen  out  1  memory write enable.
- mem_sel  out  2  byte select, same encoding as m*_size.
- mem_rdata  in  32  memory read data, combinational from mem_addr.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, wait_cnt=0, lock_cnt=0, rr_last=1.
  - m*_rvalid=0, m*_rdata=0.
  - While rst=0, m*_gnt=0, mem_wen=0, mem_addr=0 and mem_sel=0 (gated combinationally).
  - A reset in the middle of a lock drops the lock. Any pending rvalid is lost.
- Transfer and grant:
  - A transfer happens in the cycle where req & gnt = 1. At most one grant per cycle.
  - gnt is combinational from req/state/wait_cnt; requesters must hold their request signals stable until granted.
- Memory drive:
  - In the grant cycle, mem_* take the winner's addr/wdata/size, and mem_wen = winner's we.
  - With no grant: mem_wen=0 and mem_addr holds the last winner's address (no toggle).
- Read return:
  - On a granted read, mem_rdata is registered into that requester's rdata.
  - rvalid pulses for one cycle in the next cycle. Writes produce no rvalid.
  - rdata holds its value until the next read of the same port.
- States IDLE, LOCK0, LOCK1:
  - In IDLE, arbitration applies the priority rules below.
  - In LOCKx, only mx can be granted; the other gnt is forced 0.
  - IDLE -> LOCKx: on a granted mx transfer with mx_lock=1.
  - LOCKx -> IDLE: on a granted mx transfer with mx_lock=0, or when lock_cnt reaches LOCK_MAX. Force-release takes effect at the same edge.
  - In LOCKx with no mx request, the state stays LOCKx and lock_cnt keeps counting.
  - lock_cnt clears on entry to LOCKx and increments every cycle while in LOCKx.
- Priority in IDLE:
  - Only one requester: it is granted.
  - Both requesting: m0 wins, unless wait_cnt == MAX_WAIT, in which case m1 wins.
- wait_cnt:
  - Increments each cycle that m1_req=1 and m1_gnt=0, saturating at MAX_WAIT.
  - Clears on m1_gnt, or when m1_req=0.
  - Keeps counting during LOCK0, so m1 wins at the first IDLE cycle after the lock.
- Simultaneous events: a lock release and the other requester's request in the same cycle are arbitrated normally in the next cycle. No bubble is added beyond the release cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - IDLE priority alternates. When both request, the winner is the requester not recorded in rr_last.
  - rr_last updates on every grant.
  - wait_cnt and MAX_WAIT are unused; wait_cnt is tied to 0.
- Undefined: fixed priority with the starvation guard, as described above. rr_last is not implemented.

Decomposition:
- Shared package:
  - size encoding constants SZ_WORD=0, SZ_HALF=1, SZ_BYTE=2.
  - state encoding ARB_IDLE, ARB_LOCK0, ARB_LOCK1.
  - requester index constants.
- One sub-module: arb_pick, the combinational winner select. Inputs: req0, req1, state, force_m1, rr_last. Outputs: gnt0, gnt1. The top level holds the state/counters, the memory mux and the rdata registers.

Test Plan:
- Reset: hold rst=0 with both req=1 for 3 cycles -> gnt=0, mem_wen=0, rvalid=0. On release, m0 is granted in the first cycle.
- Single read: m0 reads addr 0x40 with mem_rdata=0xDEADBEEF -> m0_gnt=1 in cycle T; m0_rvalid=1 and m0_rdata=0xDEADBEEF in T+1; m1_rvalid stays 0.
- Contention/starvation (MAX_WAIT=8): m0 and m1 request continuously -> m0 granted for 8 cycles, m1 granted in cycle 9, wait_cnt then 0. The pattern repeats.
- Lock: m1 writes 0x100 with lock=1, m0 requests throughout, m1 reads 0x100 with lock=0 -> m0_gnt=0 until the cycle after the unlocking transfer.
- Lock timeout (LOCK_MAX=16): m0 locks and then deasserts req -> state returns to IDLE after 16 cycles, and m1 is granted on the next cycle.
- Byte write: m1 writes with size=2 and wdata=0x000000A5 -> mem_sel=2, mem_wen=1 for exactly one cycle, and no rvalid.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: size codes, FSM states, requester ids.
// No logic of its own; consumed by mem_port_arbiter and arb_pick.
// norm_size folds the illegal size code 3 onto word so the memory never sees it.
package mem_port_arbiter_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SZ_WORD : size;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select between m0 and m1.
// Zero latency; a lock owner is the only grantable requester, the other sees no grant.
// When both request in IDLE, m1 wins on force_m1 or when m0 held the previous grant.
import mem_port_arbiter_pkg::*;

module arb_pick (
    input  logic       req0,
    input  logic       req1,
    input  arb_state_t state,
    input  logic       force_m1,
    input  logic       rr_last,
    output logic       gnt0,
    output logic       gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            ARB_LOCK0: gnt0 = req0;
            ARB_LOCK1: gnt1 = req1;
            default: begin
                if (req0 && req1) begin
                    // Fixed-priority builds tie rr_last to m1, round-robin builds tie force_m1 low
                    if (force_m1 || (rr_last == REQ_M0))
                        gnt1 = 1'b1;
                    else
                        gnt0 = 1'b1;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory; ARB_ROUND_ROBIN_EN selects alternating priority.
// Grant and memory drive are combinational; read data returns registered one cycle after grant.
// Losers stall by holding req until gnt; m1 starvation guard after MAX_WAIT stalled cycles.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [1:0]        m0_size,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [1:0]        m1_size,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wen,
    output logic [1:0]        mem_sel,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [7:0] LOCK_END_C = 8'(LOCK_MAX - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [7:0]        wait_cnt;
    logic [7:0]        lock_cnt;
    logic              rr_last;
    logic              force_m1;
    logic              pick0;
    logic              pick1;
    logic [ADDR_W-1:0] last_addr;

    assign force_m1 = (wait_cnt == MAX_WAIT_C);

    arb_pick u_pick (
        .req0     (m0_req),
        .req1     (m1_req),
        .state    (state),
        .force_m1 (force_m1),
        .rr_last  (rr_last),
        .gnt0     (pick0),
        .gnt1     (pick1)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (m0_gnt && m0_lock)
                    state_nxt = ARB_LOCK0;
                else if (m1_gnt && m1_lock)
                    state_nxt = ARB_LOCK1;
            end
            ARB_LOCK0: begin
                if ((lock_cnt == LOCK_END_C) || (m0_gnt && !m0_lock))
                    state_nxt = ARB_IDLE;
            end
            ARB_LOCK1: begin
                if ((lock_cnt == LOCK_END_C) || (m1_gnt && !m1_lock))
                    state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, independent of the registered state
    always_comb begin
        m0_gnt    = rst & pick0;
        m1_gnt    = rst & pick1;
        mem_addr  = last_addr;
        mem_wdata = m0_wdata;
        mem_wen   = 1'b0;
        mem_sel   = SZ_WORD;
        if (!rst) begin
            mem_addr = '0;
        end else if (pick1) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wen   = m1_we;
            mem_sel   = norm_size(m1_size);
        end else if (pick0) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_wen   = m0_we;
            mem_sel   = norm_size(m0_size);
        end
    end

    // Held at zero in IDLE, so it is already clear on the first lock cycle
    always_ff @(posedge clk) begin
        if (!rst || (state == ARB_IDLE))
            lock_cnt <= '0;
        else
            lock_cnt <= lock_cnt + 8'd1;
    end

`ifdef ARB_ROUND_ROBIN_EN
    assign wait_cnt = '0;

    always_ff @(posedge clk) begin
        if (!rst)
            rr_last <= REQ_M1;
        else if (m0_gnt)
            rr_last <= REQ_M0;
        else if (m1_gnt)
            rr_last <= REQ_M1;
    end
`else
    assign rr_last = REQ_M1;

    always_ff @(posedge clk) begin
        if (!rst || !m1_req || m1_gnt)
            wait_cnt <= '0;
        else if (wait_cnt != MAX_WAIT_C)
            wait_cnt <= wait_cnt + 8'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            last_addr <= '0;
        else if (m1_gnt)
            last_addr <= m1_addr;
        else if (m0_gnt)
            last_addr <= m0_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt & ~m0_we;
            m1_rvalid <= m1_gnt & ~m1_we;
            if (m0_gnt && !m0_we)
                m0_rdata <= mem_rdata;
            if (m1_gnt && !m1_we)
                m1_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter in its default fixed-priority build.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic [1:0]  m0_size;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic [1:0]  m1_size;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wen;
    logic [1:0]  mem_sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory model: one fixed word at 0x40, otherwise a pattern derived from the address
    always_comb begin
        if (mem_addr == 32'h40)
            mem_rdata = 32'hDEADBEEF;
        else
            mem_rdata = {~mem_addr[15:0], mem_addr[15:0]};
    end

    mem_port_arbiter #(.ADDR_W(32), .MAX_WAIT(8), .LOCK_MAX(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_size   (m0_size),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_size   (m1_size),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_sel   (mem_sel),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        logic exp1, prev0, prev1;

        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 32'h40; m0_wdata = '0; m0_size = 2'd0;
        m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 32'h80; m1_wdata = '0; m1_size = 2'd0;

        // Reset held with both requesting
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
            chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
            chk("rst_wen", 32'(mem_wen), 32'd0);
            chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
            chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
            chk("rst_addr", mem_addr, 32'd0);
            chk("rst_sel", 32'(mem_sel), 32'd0);
        end

        // Release and continuous contention: m0 eight times, then m1, repeating
        prev0 = 1'b0;
        prev1 = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            next_cycle();
            if (i == 1) rst = 1'b1;
            sample();
            exp1 = (i == 9) || (i == 18);
            chk("cont_m0_gnt", 32'(m0_gnt), 32'(!exp1));
            chk("cont_m1_gnt", 32'(m1_gnt), 32'(exp1));
            chk("cont_addr", mem_addr, exp1 ? 32'h80 : 32'h40);
            chk("cont_m0_rvalid", 32'(m0_rvalid), 32'(prev0));
            chk("cont_m1_rvalid", 32'(m1_rvalid), 32'(prev1));
            if (prev0) chk("cont_m0_rdata", m0_rdata, 32'hDEADBEEF);
            if (prev1) chk("cont_m1_rdata", m1_rdata, 32'hFF7F0080);
            prev0 = !exp1;
            prev1 = exp1;
        end

        // Idle: address holds the last winner, no write strobe
        next_cycle();
        m0_req = 1'b0; m1_req = 1'b0;
        sample();
        chk("idle_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("idle_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("idle_wen", 32'(mem_wen), 32'd0);
        chk("idle_addr_hold", mem_addr, 32'h80);
        chk("idle_m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("idle_m0_rvalid", 32'(m0_rvalid), 32'd0);

        // m1 locked write, m0 blocked, m1 unlocking read
        next_cycle();
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1; m1_addr = 32'h100; m1_wdata = 32'h12345678;
        sample();
        chk("lk_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("lk_wen", 32'(mem_wen), 32'd1);
        chk("lk_addr", mem_addr, 32'h100);
        chk("lk_wdata", mem_wdata, 32'h12345678);
        chk("lk_sel", 32'(mem_sel), 32'd0);
        next_cycle();
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        sample();
        chk("lk_m1_rvalid_wr", 32'(m1_rvalid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            sample();
            chk("lk_m0_blocked", 32'(m0_gnt), 32'd0);
        end
        next_cycle();
        m1_req = 1'b1;
        sample();
        chk("lk_unlock_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("lk_unlock_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("lk_unlock_wen", 32'(mem_wen), 32'd0);
        next_cycle();
        m1_req = 1'b0;
        sample();
        chk("lk_after_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("lk_m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("lk_m1_rdata", m1_rdata, 32'hFEFF0100);
        next_cycle();
        m0_req = 1'b0;
        sample();
        chk("lk_m0_rvalid", 32'(m0_rvalid), 32'd1);

        // Lock timeout: m0 locks then goes quiet, m1 waits 16 cycles
        next_cycle();
        m0_req = 1'b1; m0_lock = 1'b1;
        sample();
        chk("to_m0_gnt", 32'(m0_gnt), 32'd1);
        next_cycle();
        m0_req = 1'b0; m0_lock = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h80;
        for (int k = 1; k <= 17; k++) begin
            if (k > 1) next_cycle();
            sample();
            chk("to_m1_gnt", 32'(m1_gnt), 32'(k == 17));
        end

        // Byte write from m1
        next_cycle();
        m1_we = 1'b1; m1_size = 2'd2; m1_wdata = 32'h000000A5; m1_addr = 32'h104;
        sample();
        chk("bw_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("bw_sel", 32'(mem_sel), 32'd2);
        chk("bw_wen", 32'(mem_wen), 32'd1);
        chk("bw_wdata", mem_wdata, 32'h000000A5);
        next_cycle();
        m1_req = 1'b0; m1_we = 1'b0; m1_size = 2'd0;
        sample();
        chk("bw_wen_off", 32'(mem_wen), 32'd0);
        chk("bw_addr_hold", mem_addr, 32'h104);
        chk("bw_no_rvalid", 32'(m1_rvalid), 32'd0);
        chk("bw_rdata_hold", m1_rdata, 32'hFF7F0080);
        next_cycle();
        sample();
        chk("bw_no_rvalid2", 32'(m1_rvalid), 32'd0);

        // Illegal size 3 drives a word select
        next_cycle();
        m0_req = 1'b1; m0_we = 1'b1; m0_size = 2'd3; m0_addr = 32'h108; m0_wdata = 32'h55;
        sample();
        chk("sz3_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("sz3_sel", 32'(mem_sel), 32'd0);
        next_cycle();
        m0_req = 1'b0; m0_we = 1'b0; m0_size = 2'd0;
        sample();
        chk("sz3_no_rvalid", 32'(m0_rvalid), 32'd0);

        // Reset in the middle of a lock drops it
        next_cycle();
        m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 32'h40;
        sample();
        chk("mr_m0_gnt", 32'(m0_gnt), 32'd1);
        next_cycle();
        rst = 1'b0; m0_req = 1'b0; m0_lock = 1'b0;
        sample();
        chk("mr_gnt_in_rst", 32'(m0_gnt), 32'd0);
        next_cycle();
        rst = 1'b1; m1_req = 1'b1; m1_addr = 32'h80;
        sample();
        chk("mr_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("mr_m0_rvalid", 32'(m0_rvalid), 32'd0);
        next_cycle();
        m1_req = 1'b0;
        sample();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
